// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants, derived totals/sync windows, and the 6-bit pixel type.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int CELL_W   = 10;
    localparam int CELL_H   = 20;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t BLACK = '{r: 2'b00, g: 2'b00, b: 2'b00};

endpackage

// File: rtl/vga_cell_scanout.sv
// VGA timing + coarse cell coordinates for the pixel layers; scrolled x cell per frame.
// Counter-to-pin latency is 2 cycles for rgb/hsync/vsync/frame_tick; no backpressure.
module vga_cell_scanout #(
    parameter int HACT = vga_timing_pkg::H_ACTIVE,
    parameter int HFP  = vga_timing_pkg::H_FP,
    parameter int HSW  = vga_timing_pkg::H_SYNC,
    parameter int HBP  = vga_timing_pkg::H_BP,
    parameter int VACT = vga_timing_pkg::V_ACTIVE,
    parameter int VFP  = vga_timing_pkg::V_FP,
    parameter int VSW  = vga_timing_pkg::V_SYNC,
    parameter int VBP  = vga_timing_pkg::V_BP,
    parameter int CW   = vga_timing_pkg::CELL_W,
    parameter int CH   = vga_timing_pkg::CELL_H
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scroll_en,
    output logic [5:0] cell_x,
    output logic [4:0] cell_y,
    input  logic [5:0] layer_rgb,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb,
    output logic       frame_tick
);
    import vga_timing_pkg::*;

    localparam int HT  = HACT + HFP + HSW + HBP;
    localparam int VT  = VACT + VFP + VSW + VBP;
    localparam int HW  = $clog2(HT);
    localparam int VW  = $clog2(VT);
    localparam int PW  = $clog2(CW + 1);
    localparam int RW  = $clog2(CH + 1);
    localparam int HS0 = HACT + HFP;
    localparam int HS1 = HS0 + HSW;
    localparam int VS0 = VACT + VFP;
    localparam int VS1 = VS0 + VSW;
    localparam int CY_MAX = VACT / CH - 1;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [PW-1:0] px_q, px_d;
    logic [RW-1:0] row_q, row_d;
    logic [5:0]    raw_x_q, raw_x_d;
    logic [4:0]    raw_y_q, raw_y_d;
    logic [5:0]    scroll_q, scroll_d;

    logic [5:0]    cell_x_q, cell_x_d;
    logic [4:0]    cell_y_q, cell_y_d;
    logic          de1_q, hs1_q, vs1_q, fr1_q;

    rgb_t          rgb_q;
    logic          hsync_q, vsync_q, frame_q;

    logic h_wrap, v_wrap, f_wrap, h_act, v_act, de0, hs0, vs0, fr0;

    always_comb begin
        h_wrap   = (h_q == HW'(HT - 1));
        v_wrap   = (v_q == VW'(VT - 1));
        f_wrap   = h_wrap && v_wrap;
        h_act    = (h_q < HW'(HACT));
        v_act    = (v_q < VW'(VACT));
        de0      = h_act && v_act;
        hs0      = !((h_q >= HW'(HS0)) && (h_q < HW'(HS1)));
        vs0      = !((v_q >= VW'(VS0)) && (v_q < VW'(VS1)));
        fr0      = (h_q == '0) && (v_q == '0);

        h_d      = h_wrap ? '0 : h_q + HW'(1);
        v_d      = v_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + VW'(1);
        end

        // x cells: prescale by CW during the active part of the line only
        px_d     = px_q;
        raw_x_d  = raw_x_q;
        if (h_wrap) begin
            px_d    = '0;
            raw_x_d = '0;
        end else if (h_act) begin
            if (px_q == PW'(CW - 1)) begin
                px_d    = '0;
                raw_x_d = raw_x_q + 6'd1;
            end else begin
                px_d    = px_q + PW'(1);
            end
        end

        // y cells advance on line ends; frame wrap wins over the line-end step
        row_d    = row_q;
        raw_y_d  = raw_y_q;
        if (f_wrap) begin
            row_d   = '0;
            raw_y_d = '0;
        end else if (h_wrap && v_act) begin
            if (row_q == RW'(CH - 1)) begin
                row_d = '0;
                if (raw_y_q != 5'(CY_MAX)) begin
                    raw_y_d = raw_y_q + 5'd1;
                end
            end else begin
                row_d = row_q + RW'(1);
            end
        end

        scroll_d = (f_wrap && scroll_en) ? scroll_q + 6'd1 : scroll_q;

        cell_x_d = de0 ? raw_x_q + scroll_q : cell_x_q;
        cell_y_d = de0 ? raw_y_q : cell_y_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q      <= '0;
            v_q      <= '0;
            px_q     <= '0;
            row_q    <= '0;
            raw_x_q  <= '0;
            raw_y_q  <= '0;
            scroll_q <= '0;
            cell_x_q <= '0;
            cell_y_q <= '0;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            fr1_q    <= 1'b0;
            rgb_q    <= BLACK;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            px_q     <= px_d;
            row_q    <= row_d;
            raw_x_q  <= raw_x_d;
            raw_y_q  <= raw_y_d;
            scroll_q <= scroll_d;
            cell_x_q <= cell_x_d;
            cell_y_q <= cell_y_d;
            de1_q    <= de0;
            hs1_q    <= hs0;
            vs1_q    <= vs0;
            fr1_q    <= fr0;
            // layer_rgb is combinational from cell_x_q/cell_y_q, so it lines up with de1_q
            rgb_q    <= de1_q ? rgb_t'(layer_rgb) : BLACK;
            hsync_q  <= hs1_q;
            vsync_q  <= vs1_q;
            frame_q  <= fr1_q;
        end
    end

    assign cell_x     = cell_x_q;
    assign cell_y     = cell_y_q;
    assign rgb        = rgb_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_q;

endmodule
